c_bus_wb_regfile: RTL and testbench

- Receiving end of the C bus: takes the value the C bus mux selects (memory or ALU result) and writes it back into the general register bank.
- One-entry writeback holding stage with a valid/ready handshake toward the C bus side and an external hold input.
- Two combinational read ports feed the A and B buses.
- Commit counter for debug and performance visibility.

---
 rtl/c_bus_pkg.sv | 17 +
 rtl/c_bus_wb_hold.sv | 84 ++++++++
 rtl/c_bus_wb_regfile.sv | 116 +++++++++++
 tb/tb_c_bus_wb_regfile.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/c_bus_pkg.sv
// Shared definitions for the C bus writeback / register file slice.
// Holds default widths, the hard-wired zero register index and the
// holding-stage state encoding.
package c_bus_pkg;

  localparam int unsigned BUS_WIDTH_DEF      = 32;
  localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
  localparam int unsigned CNT_WIDTH_DEF      = 16;
  localparam int unsigned ZERO_REG           = 0;

  // Holding stage occupancy: EMPTY means nothing waiting to commit.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/c_bus_wb_hold.sv
// One-entry writeback holding stage with valid/ready toward the C bus.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_data/in_addr  offered writeback
//   hold_in             freeze commit and acceptance while FULL
//   ready_c             combinational ready toward the C bus
//   commit_c            combinational: held entry commits at this edge
//   hold_valid/hold_data/hold_addr  registered contents of the stage
module c_bus_wb_hold
  import c_bus_pkg::*;
#(
  parameter int unsigned DATA_W = BUS_WIDTH_DEF,
  parameter int unsigned ADDR_W = REG_ADDR_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              hold_in,
  output logic              ready_c,
  output logic              commit_c,
  output logic              hold_valid,
  output logic [DATA_W-1:0] hold_data,
  output logic [ADDR_W-1:0] hold_addr
);

  hold_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              accept;

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  // Ready/commit decode and next state; a commit and an accept on the
  // same edge keep the stage FULL with the new entry.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    addr_d   = addr_q;
    ready_c  = 1'b1;
    commit_c = 1'b0;
    accept   = 1'b0;

    case (state_q)
      EMPTY: begin
        ready_c = 1'b1;
      end
      FULL: begin
        ready_c  = !hold_in;
        commit_c = !hold_in;
      end
      default: begin
        ready_c = 1'b1;
      end
    endcase

    accept = in_valid && ready_c;

    if (accept) begin
      state_d = FULL;
      data_d  = in_data;
      addr_d  = in_addr;
    end else if (commit_c) begin
      state_d = EMPTY;
    end
  end

  assign hold_valid = (state_q == FULL);
  assign hold_data  = data_q;
  assign hold_addr  = addr_q;

endmodule

// File: rtl/c_bus_wb_regfile.sv
// C bus writeback into the general register bank.
// Accepts the C bus mux output through a one-entry holding stage, commits
// it into the register array, and serves two combinational read ports
// (A and B buses). Register 0 is hard-wired to zero. A commit counter
// gives debug/performance visibility.
// Optional macro C_BUS_WB_BYPASS_EN: read ports forward the held entry
// when its (non-zero) address matches, hiding the commit latency.
// Ports:
//   CLOCK_50, RESET_InLow            clock, async active-low reset
//   IN_C_BUS/IN_C_ADDR/IN_C_VALID    writeback offer; OUT_C_READY accepts
//   IN_WB_HOLD                       freeze commit
//   IN_A_ADDR/OUT_A_BUS, IN_B_ADDR/OUT_B_BUS  read ports
//   OUT_WB_PENDING                   holding stage occupied
//   OUT_WB_COUNT                     committed writebacks (wraps)
module c_bus_wb_regfile
  import c_bus_pkg::*;
#(
  parameter int unsigned BUS_WIDTH      = BUS_WIDTH_DEF,
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET_InLow,
  input  logic [BUS_WIDTH-1:0]      IN_C_BUS,
  input  logic [REG_ADDR_WIDTH-1:0] IN_C_ADDR,
  input  logic                      IN_C_VALID,
  output logic                      OUT_C_READY,
  input  logic                      IN_WB_HOLD,
  input  logic [REG_ADDR_WIDTH-1:0] IN_A_ADDR,
  input  logic [REG_ADDR_WIDTH-1:0] IN_B_ADDR,
  output logic [BUS_WIDTH-1:0]      OUT_A_BUS,
  output logic [BUS_WIDTH-1:0]      OUT_B_BUS,
  output logic                      OUT_WB_PENDING,
  output logic [CNT_WIDTH-1:0]      OUT_WB_COUNT
);

  localparam int unsigned REG_COUNT = 1 << REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_A = REG_ADDR_WIDTH'(ZERO_REG);

  logic                      ready_c;
  logic                      commit_c;
  logic                      hold_valid;
  logic [BUS_WIDTH-1:0]      hold_data;
  logic [REG_ADDR_WIDTH-1:0] hold_addr;

  logic [BUS_WIDTH-1:0] regs_q [REG_COUNT];
  logic [BUS_WIDTH-1:0] regs_d [REG_COUNT];
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  c_bus_wb_hold #(
    .DATA_W (BUS_WIDTH),
    .ADDR_W (REG_ADDR_WIDTH)
  ) u_hold (
    .clk        (CLOCK_50),
    .rst_n      (RESET_InLow),
    .in_valid   (IN_C_VALID),
    .in_data    (IN_C_BUS),
    .in_addr    (IN_C_ADDR),
    .hold_in    (IN_WB_HOLD),
    .ready_c    (ready_c),
    .commit_c   (commit_c),
    .hold_valid (hold_valid),
    .hold_data  (hold_data),
    .hold_addr  (hold_addr)
  );

  // Register array and commit counter.
  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  // Commit: writes to register 0 are dropped but still counted.
  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (commit_c) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
      if (hold_addr != ZERO_A) begin
        regs_d[hold_addr] = hold_data;
      end
    end
  end

  // Read ports: register 0 forced to zero, optional forward of held entry.
  always_comb begin
    OUT_A_BUS = regs_q[IN_A_ADDR];
    OUT_B_BUS = regs_q[IN_B_ADDR];
    if (IN_A_ADDR == ZERO_A) begin
      OUT_A_BUS = '0;
    end
    if (IN_B_ADDR == ZERO_A) begin
      OUT_B_BUS = '0;
    end
`ifdef C_BUS_WB_BYPASS_EN
    if (hold_valid && (IN_A_ADDR == hold_addr) && (IN_A_ADDR != ZERO_A)) begin
      OUT_A_BUS = hold_data;
    end
    if (hold_valid && (IN_B_ADDR == hold_addr) && (IN_B_ADDR != ZERO_A)) begin
      OUT_B_BUS = hold_data;
    end
`endif
  end

  assign OUT_C_READY    = ready_c;
  assign OUT_WB_PENDING = hold_valid;
  assign OUT_WB_COUNT   = cnt_q;

endmodule

// File: tb/tb_c_bus_wb_regfile.sv
// Bench for c_bus_wb_regfile: directed writebacks; every accepted transfer
// pushes its expected commit count, and a monitor compares each counter
// change against the queue. Read-port values are checked directly.
module tb_c_bus_wb_regfile;

  localparam int BW = 32;
  localparam int AW = 5;
  localparam int CW = 16;
`ifdef C_BUS_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          RESET_InLow = 1'b0;
  logic [BW-1:0] IN_C_BUS = '0;
  logic [AW-1:0] IN_C_ADDR = '0;
  logic          IN_C_VALID = 1'b0;
  logic          OUT_C_READY;
  logic          IN_WB_HOLD = 1'b0;
  logic [AW-1:0] IN_A_ADDR = '0;
  logic [AW-1:0] IN_B_ADDR = '0;
  logic [BW-1:0] OUT_A_BUS;
  logic [BW-1:0] OUT_B_BUS;
  logic          OUT_WB_PENDING;
  logic [CW-1:0] OUT_WB_COUNT;

  c_bus_wb_regfile dut (
    .CLOCK_50       (clk),
    .RESET_InLow    (RESET_InLow),
    .IN_C_BUS       (IN_C_BUS),
    .IN_C_ADDR      (IN_C_ADDR),
    .IN_C_VALID     (IN_C_VALID),
    .OUT_C_READY    (OUT_C_READY),
    .IN_WB_HOLD     (IN_WB_HOLD),
    .IN_A_ADDR      (IN_A_ADDR),
    .IN_B_ADDR      (IN_B_ADDR),
    .OUT_A_BUS      (OUT_A_BUS),
    .OUT_B_BUS      (OUT_B_BUS),
    .OUT_WB_PENDING (OUT_WB_PENDING),
    .OUT_WB_COUNT   (OUT_WB_COUNT)
  );

  always #5 clk = ~clk;

  int            total_cnt = 0;
  int            pass_cnt  = 0;
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt = '0;

  task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic note_accept();
    exp_cnt++;
    exp_q.push_back(exp_cnt);
  endtask

  task automatic rd_a(input string nm, input logic [AW-1:0] addr, input logic [BW-1:0] exp);
    IN_A_ADDR = addr;
    #1;
    check(nm, OUT_A_BUS, exp);
  endtask

  // Monitor: each counter change must match the next queued commit.
  initial begin : monitor
    logic [CW-1:0] last;
    logic [CW-1:0] e;
    last = '0;
    forever begin
      @(negedge clk);
      if (!RESET_InLow) begin
        last = OUT_WB_COUNT;
      end else if (OUT_WB_COUNT !== last) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL commit_count: got %0d, want no commit", OUT_WB_COUNT);
        end else begin
          e = exp_q.pop_front();
          check("commit_count", BW'(OUT_WB_COUNT), BW'(e));
        end
        last = OUT_WB_COUNT;
      end
    end
  end

  initial begin : stim
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready",   BW'(OUT_C_READY),    32'd1);
    check("rst_pending", BW'(OUT_WB_PENDING), 32'd0);
    check("rst_count",   BW'(OUT_WB_COUNT),   32'd0);
    @(posedge clk); #1;
    RESET_InLow = 1'b1;
    for (int a = 0; a < 32; a++) begin
      tick();
      IN_A_ADDR = AW'(a);
      IN_B_ADDR = AW'(31 - a);
      #1;
      check("rst_read_a", OUT_A_BUS, 32'd0);
      check("rst_read_b", OUT_B_BUS, 32'd0);
    end

    // Single write to r5
    tick();
    IN_C_VALID = 1'b1; IN_C_ADDR = 5'd5; IN_C_BUS = 32'hDEADBEEF;
    #1;
    check("single_ready", BW'(OUT_C_READY), 32'd1);
    tick(); note_accept();
    IN_C_VALID = 1'b0;
    check("single_pending", BW'(OUT_WB_PENDING), 32'd1);
    rd_a("single_read_held", 5'd5, BYP ? 32'hDEADBEEF : 32'd0);
    tick();
    check("single_pending_clr", BW'(OUT_WB_PENDING), 32'd0);
    rd_a("single_read", 5'd5, 32'hDEADBEEF);
    check("single_count", BW'(OUT_WB_COUNT), 32'd1);

    // Back-to-back writes r1..r4
    for (int i = 1; i <= 4; i++) begin
      IN_C_VALID = 1'b1; IN_C_ADDR = AW'(i); IN_C_BUS = 32'h11 * i;
      #1;
      check("b2b_ready", BW'(OUT_C_READY), 32'd1);
      tick(); note_accept();
    end
    IN_C_VALID = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) rd_a("b2b_read", AW'(i), 32'h11 * i);
    check("b2b_count", BW'(OUT_WB_COUNT), 32'd5);

    // Hold mid-stream: r7 held while r8 is offered
    IN_C_VALID = 1'b1; IN_C_ADDR = 5'd7; IN_C_BUS = 32'h77777777;
    tick(); note_accept();
    IN_WB_HOLD = 1'b1; IN_C_ADDR = 5'd8; IN_C_BUS = 32'h88888888;
    repeat (3) begin
      #1;
      check("hold_ready", BW'(OUT_C_READY), 32'd0);
      check("hold_pending", BW'(OUT_WB_PENDING), 32'd1);
      rd_a("hold_r7", 5'd7, BYP ? 32'h77777777 : 32'd0);
      tick();
    end
    IN_WB_HOLD = 1'b0;
    #1;
    check("hold_release_ready", BW'(OUT_C_READY), 32'd1);
    tick(); note_accept();
    IN_C_VALID = 1'b0;
    IN_B_ADDR = 5'd8;
    rd_a("order_r7", 5'd7, 32'h77777777);
    check("order_r8_held", OUT_B_BUS, BYP ? 32'h88888888 : 32'd0);
    check("order_pending", BW'(OUT_WB_PENDING), 32'd1);
    tick();
    check("order_r8", OUT_B_BUS, 32'h88888888);
    check("order_pending_clr", BW'(OUT_WB_PENDING), 32'd0);

    // Register 0 write is dropped but counted
    IN_C_VALID = 1'b1; IN_C_ADDR = 5'd0; IN_C_BUS = 32'hFFFFFFFF;
    tick(); note_accept();
    IN_C_VALID = 1'b0; IN_B_ADDR = 5'd0;
    rd_a("r0_held_a", 5'd0, 32'd0);
    check("r0_held_b", OUT_B_BUS, 32'd0);
    tick();
    rd_a("r0_a", 5'd0, 32'd0);
    check("r0_b", OUT_B_BUS, 32'd0);
    check("r0_count", BW'(OUT_WB_COUNT), 32'd8);

    // Counter to all-ones, then wrap
    n = 16'hFFFF - int'(exp_cnt);
    IN_C_VALID = 1'b1; IN_C_ADDR = 5'd10;
    for (int i = 0; i < n; i++) begin
      IN_C_BUS = BW'(i);
      tick(); note_accept();
    end
    IN_C_VALID = 1'b0;
    tick();
    check("count_all_ones", BW'(OUT_WB_COUNT), 32'h0000FFFF);
    rd_a("stream_r10", 5'd10, BW'(n - 1));
    IN_C_VALID = 1'b1; IN_C_ADDR = 5'd11; IN_C_BUS = 32'h1234;
    tick(); note_accept();
    IN_C_VALID = 1'b0;
    tick();
    check("count_wrap", BW'(OUT_WB_COUNT), 32'd0);
    rd_a("wrap_r11", 5'd11, 32'h1234);

    // Read of r9 while held (forwarded only with bypass)
    IN_B_ADDR = 5'd9;
    IN_C_VALID = 1'b1; IN_C_ADDR = 5'd9; IN_C_BUS = 32'hA5A5A5A5;
    tick(); note_accept();
    IN_C_VALID = 1'b0;
    check("bypass_held_b", OUT_B_BUS, BYP ? 32'hA5A5A5A5 : 32'd0);
    tick();
    check("bypass_commit_b", OUT_B_BUS, 32'hA5A5A5A5);

    // Reset mid-operation discards the pending entry
    IN_C_VALID = 1'b1; IN_C_ADDR = 5'd12; IN_C_BUS = 32'hCAFEF00D;
    tick(); note_accept();
    IN_C_VALID = 1'b0;
    RESET_InLow = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    #1;
    check("mid_rst_pending", BW'(OUT_WB_PENDING), 32'd0);
    check("mid_rst_ready",   BW'(OUT_C_READY),    32'd1);
    check("mid_rst_count",   BW'(OUT_WB_COUNT),   32'd0);
    tick();
    RESET_InLow = 1'b1;
    tick();
    rd_a("mid_rst_r12", 5'd12, 32'd0);
    rd_a("mid_rst_r9",  5'd9,  32'd0);
    check("mid_rst_count_after", BW'(OUT_WB_COUNT), 32'd0);

    repeat (2) tick();
    check("queue_drained", BW'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
